// File: rtl/alu_ui_pkg.sv
// Shared definitions for the ALU front-panel input controller: FSM state
// encoding and the default key debounce interval.
package alu_ui_pkg;

    // 5 ms at 50 MHz
    localparam int unsigned DB_CYCLES_DEFAULT = 250000;

    typedef enum logic [1:0] {
        ENT_A  = 2'b00,
        ENT_B  = 2'b01,
        ENT_OP = 2'b10,
        SHOW   = 2'b11
    } state_e;

endpackage : alu_ui_pkg

// File: rtl/key_debounce.sv
// One raw active-low push-button: 2-flop synchroniser, stability counter,
// debounced level and a single-cycle press pulse on each accepted 1->0 change.
module key_debounce
    import alu_ui_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned      CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    // High for the one cycle after the debounced level falls.
    assign press_o = prev_q & ~level_q;

endmodule : key_debounce

// File: rtl/alu_input_ctrl.sv
// Front-panel sequencer: debounced advance/clear keys step through operand A,
// operand B and op entry, then enable the ALU/display in SHOW.
module alu_input_ctrl
    import alu_ui_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw,
    input  logic       key_adv_n,
    input  logic       key_clr_n,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic [1:0] op,
    output logic       en,
    output logic [1:0] stage
);

    logic adv_pulse, clr_pulse;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adv (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_adv_n),
        .press_o (adv_pulse)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_clr_n),
        .press_o (clr_pulse)
    );

    state_e     state_q, state_d;
    logic [2:0] a_q, a_d, b_q, b_d;
    logic [1:0] op_q, op_d;
    logic       en_q, en_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        // Clear has priority; a coincident advance is dropped.
        if (clr_pulse) begin
            state_d = ENT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (adv_pulse) begin
            unique case (state_q)
                ENT_A: begin
                    a_d     = sw;
                    state_d = ENT_B;
                end
                ENT_B: begin
                    b_d     = sw;
                    state_d = ENT_OP;
                end
                ENT_OP: begin
                    op_d    = sw[1:0];
                    state_d = SHOW;
                end
                SHOW: begin
                    state_d = ENT_A;
                end
                default: state_d = ENT_A;
            endcase
        end
        en_d = (state_d == SHOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            en_q    <= en_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign op    = op_q;
    assign en    = en_q;
    assign stage = state_q;

endmodule : alu_input_ctrl

// File: doc/alu_input_ctrl.md
ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 250000, meaning the number of consecutive stable cycles before a key level is accepted (5 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sw  input  3  raw slide switches supplying operand/op value.
REQ-005 SHALL have port key_adv_n  input  1  raw active-low push-button, advance.
REQ-006 SHALL have port key_clr_n  input  1  raw active-low push-button, clear.
REQ-007 SHALL have port A  output  3  latched operand A.
REQ-008 SHALL have port B  output  3  latched operand B.
REQ-009 SHALL have port op  output  2  latched op code (00 xnor, 01 shift, 10 add, 11 mult).
REQ-010 SHALL have port en  output  1  display/ALU enable; high only in SHOW.
REQ-011 SHALL have port stage  output  2  current FSM state encoding, for display prompting.

Function
REQ-012 SHALL pass each raw key through a 2-flop synchroniser before any other use.
REQ-013 SHALL maintain a per-key debounced level, updated only after the synchronised level has differed from it for DB_CYCLES consecutive cycles; any agreement cycle clears the count.
REQ-014 SHALL generate a one-cycle press pulse on the cycle after the debounced level changes 1->0; a 0->1 change generates nothing.
REQ-015 SHALL produce exactly one press pulse per held press, regardless of hold length.
REQ-016 SHALL ignore glitches shorter than DB_CYCLES cycles.
REQ-017 SHALL implement states ENT_A=00, ENT_B=01, ENT_OP=10, SHOW=11, with stage equal to the state.
REQ-018 On an advance pulse in ENT_A, SHALL set A<=sw and move to ENT_B.
REQ-019 On an advance pulse in ENT_B, SHALL set B<=sw and move to ENT_OP.
REQ-020 On an advance pulse in ENT_OP, SHALL set op<=sw[1:0], ignore sw[2], and move to SHOW.
REQ-021 On an advance pulse in SHOW, SHALL move to ENT_A while holding A, B and op.
REQ-022 SHALL register en as 1 exactly while the state is SHOW; the output updates on the same edge as the state.
REQ-023 On a clear pulse in any state, SHALL set A, B and op to 0, en to 0, and the state to ENT_A.
REQ-024 If clear and advance pulses occur in the same cycle, clear SHALL win and the advance SHALL be discarded.
REQ-025 SHALL ignore sw changes outside an advance pulse; outputs hold.
REQ-026 SHALL update outputs one cycle after the pulse; no other latency is added.

Reset
REQ-027 Asserting rst_n low, at any time including mid-debounce, SHALL immediately force A=0, B=0, op=00, en=0, and state ENT_A.
REQ-028 The same reset SHALL set synchroniser flops and debounced levels to 1 (released) and debounce counters to 0.
REQ-029 After reset release, a key held low SHALL produce a press pulse only after a full DB_CYCLES qualification.

Structure
REQ-030 Package alu_ui_pkg SHALL hold the state encoding constants and the DB_CYCLES default.
REQ-031 Sub-module key_debounce (synchroniser, counter, debounced level, press pulse) SHALL be instantiated once per key.
REQ-032 The counter width SHALL be $clog2(DB_CYCLES+1).

Verification (DB_CYCLES=4)
REQ-033 Reset, then press advance three times with sw=101, 011, 110 -> A=101, B=011, op=10, en=1, stage=11.
REQ-034 Drive advance low for 3 cycles, then high -> no pulse, stage stays 00, outputs stay 0.
REQ-035 Hold advance low for 50 cycles -> exactly one transition ENT_A->ENT_B, occurring 2+4+1 to 2+4+2 cycles after the fall.
REQ-036 In SHOW with A=101, press clear and advance simultaneously -> A=B=op=0, en=0, stage=00.
REQ-037 In ENT_B, toggle sw every cycle without a key press -> A and B unchanged.
REQ-038 Assert rst_n mid-debounce of a press -> immediate all-zero outputs; no pulse after release until the key is re-qualified for 4 cycles.
